// File: rtl/pkg_RV32.sv
// Shared RV32 definitions: data width, full byte-enable mask and
// the state encoding of the unified-memory arbiter.
package pkg_RV32;

  localparam int XLEN = 32;

  localparam logic [3:0] BE_ALL = 4'hF;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_IFETCH = 2'd1,
    ARB_DACC   = 2'd2,
    ARB_IKILL  = 2'd3
  } arbState_t;

endpackage

// File: rtl/memarb_rv32.sv
// Unified-memory arbiter: one access at a time, data first, fetch
// guaranteed a slot after STARVE_LIM back-to-back data grants.
// Ports: iCLK/iRST (sync, active-low); fetch side iIReq/iIADDR/
// iBRANCH -> oIDATA/oIValid/oStallI; data side iDReq/iDWE/iDBE/
// iDADDR/iDWDATA -> oDRDATA/oDValid/oStallD; memory side
// oMReq/oMWE/oMBE/oMADDR/oMWDATA <- iMRDATA/iMAck.
module memarb_rv32
  import pkg_RV32::*;
#(
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic            iCLK,
  input  logic            iRST,
  input  logic            iIReq,
  input  logic [XLEN-1:0] iIADDR,
  input  logic            iBRANCH,
  output logic [XLEN-1:0] oIDATA,
  output logic            oIValid,
  output logic            oStallI,
  input  logic            iDReq,
  input  logic            iDWE,
  input  logic [3:0]      iDBE,
  input  logic [XLEN-1:0] iDADDR,
  input  logic [XLEN-1:0] iDWDATA,
  output logic [XLEN-1:0] oDRDATA,
  output logic            oDValid,
  output logic            oStallD,
  output logic            oMReq,
  output logic            oMWE,
  output logic [3:0]      oMBE,
  output logic [XLEN-1:0] oMADDR,
  output logic [XLEN-1:0] oMWDATA,
  input  logic [XLEN-1:0] iMRDATA,
  input  logic            iMAck
);

  localparam logic [3:0] LIM = 4'(STARVE_LIM);
  localparam logic [XLEN-1:0] IA_MASK = 32'hFFFF_FFFC;

  arbState_t state, stateNx;
  logic [3:0] dcnt, dcntNx;

  logic            mReqNx, mWENx;
  logic [3:0]      mBENx;
  logic [XLEN-1:0] mAddrNx, mWDataNx;
  logic [XLEN-1:0] iDataNx, dRDataNx;
  logic            iValidNx, dValidNx;

  logic starved, grantI, grantD;

  // A fetch address seen together with a branch is stale.
  assign starved = (dcnt == LIM);
  assign grantI  = iIReq & ~iBRANCH & (~iDReq | starved);
  assign grantD  = iDReq & ~grantI;

  assign oStallI = iIReq & ~oIValid;
  assign oStallD = iDReq & ~oDValid;

  always_comb begin
    stateNx  = state;
    dcntNx   = dcnt;
    mReqNx   = oMReq;
    mWENx    = oMWE;
    mBENx    = oMBE;
    mAddrNx  = oMADDR;
    mWDataNx = oMWDATA;
    iDataNx  = oIDATA;
    dRDataNx = oDRDATA;
    iValidNx = 1'b0;
    dValidNx = 1'b0;
    unique case (state)
      ARB_IDLE: begin
        unique case (1'b1)
          grantI: begin
            stateNx = ARB_IFETCH;
            dcntNx  = '0;
            mReqNx  = 1'b1;
            mWENx   = 1'b0;
            mBENx   = BE_ALL;
            mAddrNx = iIADDR & IA_MASK;
          end
          grantD: begin
            stateNx  = ARB_DACC;
            // Count only grants that made a fetch wait.
            if (!iIReq)
              dcntNx = '0;
            else if (!starved)
              dcntNx = dcnt + 4'd1;
            mReqNx   = 1'b1;
            mWENx    = iDWE;
            mBENx    = iDBE;
            mAddrNx  = iDADDR;
            mWDataNx = iDWDATA;
          end
          default: ;
        endcase
      end
      ARB_IFETCH: begin
        if (iMAck) begin
          mReqNx  = 1'b0;
          stateNx = ARB_IDLE;
          if (!iBRANCH) begin
            iDataNx  = iMRDATA;
            iValidNx = 1'b1;
          end
        end else if (iBRANCH) begin
          stateNx = ARB_IKILL;
        end
      end
      ARB_IKILL: begin
        if (iMAck) begin
          mReqNx  = 1'b0;
          stateNx = ARB_IDLE;
        end
      end
      ARB_DACC: begin
        if (iMAck) begin
          mReqNx   = 1'b0;
          stateNx  = ARB_IDLE;
          dRDataNx = iMRDATA;
          dValidNx = 1'b1;
        end
      end
      default: stateNx = ARB_IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST) begin
      state   <= ARB_IDLE;
      dcnt    <= '0;
      oMReq   <= 1'b0;
      oMWE    <= 1'b0;
      oMBE    <= '0;
      oMADDR  <= '0;
      oMWDATA <= '0;
      oIDATA  <= '0;
      oDRDATA <= '0;
      oIValid <= 1'b0;
      oDValid <= 1'b0;
    end else begin
      state   <= stateNx;
      dcnt    <= dcntNx;
      oMReq   <= mReqNx;
      oMWE    <= mWENx;
      oMBE    <= mBENx;
      oMADDR  <= mAddrNx;
      oMWDATA <= mWDataNx;
      oIDATA  <= iDataNx;
      oDRDATA <= dRDataNx;
      oIValid <= iValidNx;
      oDValid <= dValidNx;
    end
  end

endmodule

// File: tb/tb_memarb_rv32.sv
// Bench for memarb_rv32: transaction-level model plus memory
// responder, per-cycle compare, and directed scenario checks.
module tb_memarb_rv32;
  import pkg_RV32::*;

  localparam int LIM = 4;

  logic        iCLK = 0, iRST = 0;
  logic        iIReq = 0, iBRANCH = 0;
  logic [31:0] iIADDR = 0;
  logic        iDReq = 0, iDWE = 0;
  logic [3:0]  iDBE = 0;
  logic [31:0] iDADDR = 0, iDWDATA = 0;
  logic [31:0] iMRDATA = 0;
  logic        iMAck = 0;
  logic [31:0] oIDATA, oDRDATA, oMADDR, oMWDATA;
  logic        oIValid, oStallI, oDValid, oStallD;
  logic        oMReq, oMWE;
  logic [3:0]  oMBE;

  memarb_rv32 #(.STARVE_LIM(LIM)) dut (
    .iCLK(iCLK), .iRST(iRST),
    .iIReq(iIReq), .iIADDR(iIADDR), .iBRANCH(iBRANCH),
    .oIDATA(oIDATA), .oIValid(oIValid), .oStallI(oStallI),
    .iDReq(iDReq), .iDWE(iDWE), .iDBE(iDBE),
    .iDADDR(iDADDR), .iDWDATA(iDWDATA),
    .oDRDATA(oDRDATA), .oDValid(oDValid), .oStallD(oStallD),
    .oMReq(oMReq), .oMWE(oMWE), .oMBE(oMBE),
    .oMADDR(oMADDR), .oMWDATA(oMWDATA),
    .iMRDATA(iMRDATA), .iMAck(iMAck)
  );

  always #5 iCLK = ~iCLK;

  int nChk = 0, nPass = 0;
  bit chkOn = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    nChk++;
    if (act === exp) nPass++;
    else $display("FAIL %s: got %h want %h", nm, act, exp);
  endtask

  function automatic logic [31:0] memRd(input logic [31:0] a);
    return (a == 32'h100) ? 32'h13 : (a ^ 32'h5A5A_0000);
  endfunction

  // Transaction model: at most one access outstanding.
  bit          mOut = 0, mFetch = 0, mKilled = 0;
  int          mAge = 0, mStreak = 0;
  logic [31:0] mAddr = 0, mWData = 0, mIData = 0, mDData = 0;
  logic        mWE = 0, mIV = 0, mDV = 0;
  logic [3:0]  mBE = 0;
  int          ackDelay = 0;

  always @(posedge iCLK) begin
    if (!iRST) begin
      mOut = 0; mFetch = 0; mKilled = 0; mAge = 0;
      mStreak = 0; mAddr = 0; mWData = 0; mIData = 0;
      mDData = 0; mWE = 0; mBE = 0; mIV = 0; mDV = 0;
    end else begin
      mIV = 0;
      mDV = 0;
      if (mOut) begin
        if (iMAck) begin
          mOut = 0;
          if (!mFetch) begin
            mDV = 1; mDData = iMRDATA;
          end else if (!mKilled && !iBRANCH) begin
            mIV = 1; mIData = iMRDATA;
          end
        end else begin
          if (mFetch && iBRANCH) mKilled = 1;
          mAge++;
        end
      end else if (iIReq && !iBRANCH &&
                   (!iDReq || mStreak >= LIM)) begin
        mOut = 1; mFetch = 1; mKilled = 0; mAge = 0;
        mAddr = iIADDR & ~32'h3; mWE = 0; mBE = 4'hF;
        mStreak = 0;
      end else if (iDReq) begin
        mOut = 1; mFetch = 0; mKilled = 0; mAge = 0;
        mAddr = iDADDR; mWE = iDWE; mBE = iDBE;
        mWData = iDWDATA;
        if (!iIReq) mStreak = 0;
        else if (mStreak < LIM) mStreak++;
      end
    end
  end

  // Memory: ack after ackDelay waiting cycles of a request.
  always @(posedge iCLK) begin
    #2;
    iMAck   = mOut && (mAge == ackDelay);
    iMRDATA = mOut ? memRd(mAddr) : 32'h0;
  end

  always @(negedge iCLK) begin
    if (chkOn) begin
      chk("oMReq", {31'b0, oMReq}, {31'b0, mOut});
      chk("oMADDR", oMADDR, mAddr);
      chk("oMWE", {31'b0, oMWE}, {31'b0, mWE});
      chk("oMBE", {28'b0, oMBE}, {28'b0, mBE});
      chk("oMWDATA", oMWDATA, mWData);
      chk("oIValid", {31'b0, oIValid}, {31'b0, mIV});
      chk("oIDATA", oIDATA, mIData);
      chk("oDValid", {31'b0, oDValid}, {31'b0, mDV});
      chk("oDRDATA", oDRDATA, mDData);
      chk("oStallI", {31'b0, oStallI},
          {31'b0, iIReq & ~mIV});
      chk("oStallD", {31'b0, oStallD},
          {31'b0, iDReq & ~mDV});
    end
  end

  // Event log: grant kinds (1 = fetch), valid counts.
  bit grants[$];
  int grantCyc[$];
  int cyc = 0, nIV = 0, nDV = 0, dvCyc = 0;
  logic prevMReq = 0;

  always @(negedge iCLK) begin
    cyc++;
    if (oMReq === 1'b1 && prevMReq !== 1'b1) begin
      grants.push_back(oMADDR < 32'h1000);
      grantCyc.push_back(cyc);
    end
    if (oIValid === 1'b1) nIV++;
    if (oDValid === 1'b1) begin
      nDV++;
      dvCyc = cyc;
    end
    prevMReq = oMReq;
  end

  task automatic nextCyc();
    @(negedge iCLK);
    #1;
  endtask

  task automatic waitFor(input int which, input int n,
                         input int maxc, input string nm);
    bit ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      nextCyc();
      case (which)
        0: ok = (oIValid === 1'b1);
        1: ok = (oDValid === 1'b1);
        default: ok = (grants.size() >= n);
      endcase
    end
    if (!ok) begin
      nChk++;
      $display("FAIL timeout %s: no event in %0d cycles",
               nm, maxc);
    end
  endtask

  int c0, n0;
  logic [31:0] pat;
  bit ok;

  initial begin
    nextCyc();
    chkOn = 1;
    nextCyc();
    chk("rst oMReq", {31'b0, oMReq}, 32'h0);
    chk("rst oMADDR", oMADDR, 32'h0);
    chk("rst oIDATA", oIDATA, 32'h0);
    iRST = 1;
    nextCyc();

    // Fetch only, ack 3 cycles into the request.
    ackDelay = 3;
    iIADDR = 32'h100; iIReq = 1; c0 = cyc;
    waitFor(0, 0, 20, "fetch1");
    chk("fetch1 data", oIDATA, 32'h13);
    chk("fetch1 latency", cyc - c0, 5);
    chk("fetch1 addr", oMADDR, 32'h100);
    iIReq = 0;
    repeat (2) nextCyc();

    // Load and fetch together: data wins.
    grants.delete(); grantCyc.delete();
    ackDelay = 1;
    iDADDR = 32'h2000; iDWE = 0; iDBE = 4'hF;
    iIADDR = 32'h104; iDReq = 1; iIReq = 1;
    waitFor(1, 0, 20, "load2");
    chk("load2 data", oDRDATA, 32'h5A5A_2000);
    iDReq = 0;
    waitFor(0, 0, 20, "fetch2");
    chk("fetch2 data", oIDATA, 32'h5A5A_0104);
    iIReq = 0;
    chk("order2 first", {31'b0, grants[0]}, 32'h0);
    chk("order2 second", {31'b0, grants[1]}, 32'h1);
    chk("fetch2 after dvalid", grantCyc[1] - dvCyc, 1);
    repeat (2) nextCyc();

    // Starvation: 4 data grants, 1 fetch, then data.
    grants.delete(); grantCyc.delete();
    ackDelay = 0;
    iDADDR = 32'h3000; iIADDR = 32'h108;
    iDReq = 1; iIReq = 1;
    waitFor(2, 6, 60, "starve");
    iDReq = 0; iIReq = 0;
    repeat (4) nextCyc();
    pat = 0;
    for (int i = 0; i < 6; i++)
      if (i < grants.size()) pat[i] = grants[i];
    chk("starve pattern", pat, 32'h10);

    // Branch one cycle into the fetch.
    grants.delete(); grantCyc.delete();
    n0 = nIV; ackDelay = 3;
    iIADDR = 32'h200; iIReq = 1;
    waitFor(2, 1, 20, "kill grant");
    iBRANCH = 1; iIADDR = 32'h40;
    nextCyc();
    iBRANCH = 0;
    chk("kill state", 32'(dut.state), 32'(ARB_IKILL));
    waitFor(0, 0, 30, "fetch after kill");
    chk("refetch data", oIDATA, 32'h5A5A_0040);
    chk("refetch addr", oMADDR, 32'h40);
    iIReq = 0;
    repeat (2) nextCyc();
    chk("kill ivalids", nIV - n0, 1);
    chk("kill grants", grants.size(), 2);

    // Branch in the ack cycle.
    grants.delete(); grantCyc.delete();
    n0 = nIV; ackDelay = 2;
    iIADDR = 32'h300; iIReq = 1;
    waitFor(2, 1, 20, "coin grant");
    ok = 0;
    for (int i = 0; i < 10 && !ok; i++) begin
      if (iMAck) ok = 1;
      else nextCyc();
    end
    chk("coin ack seen", {31'b0, ok}, 32'h1);
    iBRANCH = 1; iIReq = 0;
    nextCyc();
    iBRANCH = 0;
    chk("coin state", 32'(dut.state), 32'(ARB_IDLE));
    chk("coin mreq", {31'b0, oMReq}, 32'h0);
    chk("coin ivalid", {31'b0, oIValid}, 32'h0);
    repeat (3) nextCyc();
    chk("coin ivalids", nIV - n0, 0);

    // Reset in the middle of a data access.
    grants.delete(); grantCyc.delete();
    ackDelay = 100;
    iDADDR = 32'h4000; iDWE = 0; iDBE = 4'hF; iDReq = 1;
    waitFor(2, 1, 20, "rst grant");
    nextCyc();
    chk("pre-rst mreq", {31'b0, oMReq}, 32'h1);
    iRST = 0; iDReq = 0;
    nextCyc();
    chk("mid-rst mreq", {31'b0, oMReq}, 32'h0);
    chk("mid-rst maddr", oMADDR, 32'h0);
    chk("mid-rst mbe", {28'b0, oMBE}, 32'h0);
    chk("mid-rst idata", oIDATA, 32'h0);
    chk("mid-rst drdata", oDRDATA, 32'h0);
    chk("mid-rst state", 32'(dut.state), 32'(ARB_IDLE));
    iRST = 1;
    nextCyc();

    // Store after reset.
    grants.delete(); grantCyc.delete();
    n0 = nDV; ackDelay = 1;
    iDADDR = 32'h5000; iDWE = 1; iDBE = 4'b0011;
    iDWDATA = 32'hDEAD_BEEF; iDReq = 1;
    waitFor(2, 1, 20, "store grant");
    chk("store wdata", oMWDATA, 32'hDEAD_BEEF);
    chk("store be", {28'b0, oMBE}, 32'h3);
    chk("store we", {31'b0, oMWE}, 32'h1);
    chk("store addr", oMADDR, 32'h5000);
    waitFor(1, 0, 20, "store done");
    iDReq = 0;
    repeat (3) nextCyc();
    chk("store dvalids", nDV - n0, 1);

    $display("%0d/%0d checks passed", nPass, nChk);
    $finish;
  end

endmodule

// File: doc/memarb_rv32.md
# memarb_RV32

Arbiter and sequencer for the single-ported unified memory shared by the instruction fetch stage and the data access stage of the RV32I pipeline. It grants one transaction at a time, drives the memory request/acknowledge handshake, and returns fetch or load data. It generates the `oStallI`/`oStallD` signals that hold the PC and pipeline registers. A taken branch kills an in-flight fetch so its stale instruction is never delivered.

## Interface
- `STARVE_LIM`, default 4: maximum consecutive data grants while a fetch is waiting; legal range 1..15.
- `iCLK` input 1: clock; all logic is on the rising edge.
- `iRST` input 1: synchronous, active-low reset.
- `iIReq` input 1: fetch request; held until `oIValid`.
- `iIADDR` input 32: fetch address; bits [1:0] are ignored.
- `iBRANCH` input 1: taken-branch pulse; kills any pending or in-flight fetch.
- `oIDATA` output 32: fetched instruction; valid while `oIValid`.
- `oIValid` output 1: one-cycle fetch completion pulse.
- `oStallI` output 1: fetch stall, computed as `iIReq & ~oIValid`.
- `iDReq` input 1: data request; held until `oDValid`.
- `iDWE` input 1: 1 = store, 0 = load.
- `iDBE` input 4: byte enables for a store.
- `iDADDR` input 32: data address, word-aligned.
- `iDWDATA` input 32: store data.
- `oDRDATA` output 32: load data; valid while `oDValid`.
- `oDValid` output 1: one-cycle data completion pulse, for both loads and stores.
- `oStallD` output 1: data stall, computed as `iDReq & ~oDValid`.
- `oMReq` output 1: memory request; held until `iMAck`.
- `oMWE` output 1: memory write enable.
- `oMBE` output 4: memory byte enables.
- `oMADDR` output 32: memory address.
- `oMWDATA` output 32: memory write data.
- `iMRDATA` input 32: memory read data; valid in the `iMAck` cycle.
- `iMAck` input 1: one-cycle acknowledge; ignored while `oMReq` = 0.

## Operation
- FSM states: `IDLE`, `IFETCH`, `DACC`, `IKILL`.
- **IDLE:** sample the requests and grant one of them.
  - Data has priority.
  - Exception: a fetch is granted instead when `iIReq` & `iDReq` are both high and `dcnt` == `STARVE_LIM`.
  - A fetch is never granted in a cycle where `iBRANCH` = 1, because its address is stale. A data grant is still allowed in that cycle.
- **Grant:** register `oMADDR`/`oMWE`/`oMBE`/`oMWDATA` and set `oMReq`. Fetch grants use `oMWE` = 0 and `oMBE` = 4'hF.
  - Fetch grant: go to `IFETCH` and clear `dcnt`.
  - Data grant: go to `DACC`. Increment `dcnt` if `iIReq` is high; otherwise clear it. `dcnt` saturates at `STARVE_LIM`.
- **IFETCH:** on `iMAck`, clear `oMReq`, register `iMRDATA` into `oIDATA`, pulse `oIValid`, and go to `IDLE`.
  - `iBRANCH` while waiting (no ack in the same cycle): go to `IKILL`.
  - `iBRANCH` in the same cycle as `iMAck`: the fetch is killed, so there is no `oIValid` and the state goes to `IDLE`.
- **IKILL:** keep `oMReq` high until `iMAck`, discard the data, then go to `IDLE`. `oIValid` is never asserted from this state.
- **DACC:** on `iMAck`, clear `oMReq`, register `iMRDATA` into `oDRDATA` (stores included; the value is don't-care), pulse `oDValid`, and go to `IDLE`. `iBRANCH` has no effect in this state.
- **Reset:** while `iRST` = 0, from any state including mid-transaction:
  - go to `IDLE` with `dcnt` = 0;
  - all outputs go to 0: `oMReq`, `oMWE`, `oMBE`, `oMADDR`, `oMWDATA`, `oIDATA`, `oDRDATA`, `oIValid`, `oDValid`.
  - The memory shares this reset and drops any outstanding access.
- Address, enable and write data stay stable while `oMReq` = 1.

## Timing
- Request seen in `IDLE` at cycle N: `oMReq` = 1 from N+1.
- `iMAck` arrives at cycle A ≥ N+1.
- At A+1: `oIValid`/`oDValid` = 1, `oMReq` = 0, state = `IDLE`. The requester drops its request at A+2, or holds it for a new access.
- Minimum latency is 2 cycles from request to valid. Peak throughput is one access per 2 cycles. The arbiter never grants a second transaction while one is outstanding.
- `oStallI`/`oStallD` are combinational from the request inputs and registered valids. There is no path from `iMAck` to the stalls.

## Structure
- Shared package `pkg_RV32`: state encodings `ARB_IDLE`=2'd0, `ARB_IFETCH`=2'd1, `ARB_DACC`=2'd2, `ARB_IKILL`=2'd3; `XLEN`=32; `BE_ALL`=4'hF.
- Single module, no sub-module. `dcnt` is a 4-bit counter inside the module.

## Test plan
- **Fetch only:** `iIReq`, `iIADDR`=0x100, memory acks 3 cycles after `oMReq`, `iMRDATA`=0x00000013 → `oMADDR`=0x100, `oIValid` for 1 cycle with `oIDATA`=0x13, `oStallI` high until then.
- **Load plus fetch, same cycle:** data `iDADDR`=0x2000 is granted first. Fetch is granted in the `IDLE` cycle after `oDValid`. `oStallI` stays high throughout.
- **Starvation:** `iDReq` held high, `iIReq` held high, `STARVE_LIM`=4 → exactly 4 data grants, then 1 fetch grant, then data again.
- **Branch kill:** `iBRANCH` pulsed 1 cycle into `IFETCH` with ack 2 cycles later → state passes through `IKILL`, no `oIValid`. The next fetch, to the new `iIADDR`=0x40, completes normally.
- **Branch coincident with ack:** `iBRANCH` and `iMAck` in the same cycle → no `oIValid`, state goes to `IDLE`.
- **Reset mid-access:** `iRST`=0 while in `DACC` with `oMReq`=1 → next cycle all outputs are 0 and the state is `IDLE`. After release, a store of 0xDEADBEEF with `oMBE`=4'b0011 completes with one `oDValid`.
